// File: rtl/neo_cmc_pkg.sv
// ---------------------------------------------------------------------------
// neo_cmc_pkg
//   Shared definitions for the NEO-CMC fix-layer bankswitch tracker:
//   operating modes, the fix-map addresses and data words that the tracker
//   snoops for, and the address-page selectors used by the write/trigger
//   decoders.
//   No ports (package).
// ---------------------------------------------------------------------------
package neo_cmc_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_LINE   = 2'd1,
      MODE_COL    = 2'd2,
      MODE_DIRECT = 2'd3
   } mode_e;

   // Fix-map word fetched at the start of every frame.
   localparam logic [10:0] FRAME_ADDR  = 11'h7E2;
   // Fix-map word that carries the direct-mode bank value.
   localparam logic [10:0] DIRECT_ADDR = 11'h7E0;
   // Data word that arms a line-table entry.
   localparam logic [11:0] ARM_WORD    = 12'h200;
   // Column-table bits written by one fix-map word.
   localparam int          GROUP_BITS  = 12;

   // Line-table write select: {ADDR[6], ADDR[0], ADDR[10:8]}.
   localparam logic [4:0]  LINE_WR_SEL = 5'b00101;
   // ADDR[10:8] page of line-table triggers and column-table writes.
   localparam logic [2:0]  TRIG_PAGE   = 3'd7;
   localparam logic [2:0]  COL_WR_PAGE = 3'd5;
   // PBUS[14:12] tags.
   localparam logic [2:0]  TAG_PLAIN   = 3'd0;
   localparam logic [2:0]  TAG_CMD     = 3'd7;

   // True when the fetched word is a frame-start marker.
   function automatic logic is_frame_start(input logic [10:0] addr,
                                           input logic [14:0] pbus);
      return (addr == FRAME_ADDR) && (pbus[14:12] == TAG_PLAIN);
   endfunction

endpackage : neo_cmc_pkg

// File: rtl/neo_cmc_line_table.sv
// ---------------------------------------------------------------------------
// neo_cmc_line_table
//   Line-table half of the bankswitch tracker. Holds LINES entries of
//   {arm, lo, bank}, decodes entry writes from the snooped fetch stream,
//   walks a line counter on trigger fetches and reports when the entry of
//   the current line should load its bank.
// Ports
//   CLK, RESET   system clock, synchronous active-high reset
//   tick         one-cycle PCK2B strobe; state only moves on ticks
//   stable       ADDR equals the address seen on the previous tick
//   line_mode    tracker is in line-table mode
//   clear        mode-change tick: restart line counter and skip flag
//   frame        frame-start tick: restart line counter and skip flag
//   addr, pbus   snooped fix-map address / data
//   hit          current line's entry loads BANK on this tick
//   hit_bank     bank value of the current line's entry
// ---------------------------------------------------------------------------
module neo_cmc_line_table #(
   parameter int BANK_W = 2,
   parameter int LINES  = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              tick,
   input  logic              stable,
   input  logic              line_mode,
   input  logic              clear,
   input  logic              frame,
   input  logic [10:0]       addr,
   input  logic [14:0]       pbus,
   output logic              hit,
   output logic [BANK_W-1:0] hit_bank
);
   import neo_cmc_pkg::*;

   localparam int IDX_W = $clog2(LINES);

   logic [LINES-1:0]             arm_q, arm_d;
   logic [LINES-1:0]             lo_q, lo_d;
   logic [LINES-1:0][BANK_W-1:0] bank_q, bank_d;
   logic [IDX_W-1:0]             line_q, line_d;
   logic                         skip_q, skip_d;

   logic [IDX_W-1:0] wr_idx;
   logic             wr_en;
   logic             trig;

   assign wr_idx = addr[IDX_W:1];
   assign wr_en  = tick & stable & line_mode &
                   ({addr[6], addr[0], addr[10:8]} == LINE_WR_SEL);
   assign trig   = tick & stable & line_mode &
                   (addr[10:8] == TRIG_PAGE) & (pbus[14:12] == TAG_PLAIN);

   // Reads use the registered entries, so a same-tick write is seen next time.
   assign hit      = trig & arm_q[line_q] & lo_q[line_q] & ~skip_q;
   assign hit_bank = bank_q[line_q];

   always_comb begin
      // NOTE: every _d starts as its _q, so each path through this block
      // assigns every output and no latch can be inferred.
      arm_d  = arm_q;
      lo_d   = lo_q;
      bank_d = bank_q;
      line_d = line_q;
      skip_d = skip_q;

      if (wr_en) begin
         if (addr[7]) begin
            bank_d[wr_idx] = ~pbus[BANK_W-1:0];
            lo_d[wr_idx]   = &pbus[11:8];
         end else begin
            arm_d[wr_idx]  = (pbus[11:0] == ARM_WORD);
         end
      end

      // Mode change and frame start both restart the walk and win over a trigger.
      if (clear || frame) begin
         line_d = '0;
         skip_d = 1'b0;
      end else if (hit) begin
         // One load per line: the next trigger on this line advances instead.
         skip_d = 1'b1;
      end else if (trig) begin
         line_d = line_q + 1'b1;   // LINES is a power of two: wraps naturally
         skip_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: the table is a small flop array that must come out of reset
      // empty, so it is cleared here with everything else rather than left
      // uninitialised like a RAM.
      if (RESET) begin
         arm_q  <= '0;
         lo_q   <= '0;
         bank_q <= '0;
         line_q <= '0;
         skip_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the
         // pre-edge values regardless of statement order.
         arm_q  <= arm_d;
         lo_q   <= lo_d;
         bank_q <= bank_d;
         line_q <= line_d;
         skip_q <= skip_d;
      end
   end

endmodule : neo_cmc_line_table

// File: rtl/neo_cmc_bank_gen.sv
// ---------------------------------------------------------------------------
// neo_cmc_bank_gen
//   NEO-CMC fix-layer bankswitch tracker. Snoops fix-map fetches on PCK2B
//   ticks and drives the fix tile bank to the fix ROM address mux. Supports
//   line-table, column-table and direct-register modes.
// Ports
//   CLK       system clock
//   RESET     synchronous active-high reset
//   PCK2B_EN  one-CLK strobe per PCK2B rising edge ("tick")
//   PBUS      fix-map data word being fetched
//   ADDR      fix-map word address being fetched
//   MODE      0 off, 1 line table, 2 column table, 3 direct register
//   BANK      current fix tile bank (registered)
// ---------------------------------------------------------------------------
module neo_cmc_bank_gen #(
   parameter int BANK_W     = 2,
   parameter int LINES      = 32,
   parameter int COLS       = 40,
   parameter int FRAME_BANK = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              PCK2B_EN,
   input  logic [14:0]       PBUS,
   input  logic [10:0]       ADDR,
   input  logic [1:0]        MODE,
   output logic [BANK_W-1:0] BANK
);
   import neo_cmc_pkg::*;

   localparam int                TBL_W     = COLS * BANK_W;
   localparam logic [BANK_W-1:0] FRAME_VAL = BANK_W'(FRAME_BANK);

   mode_e              mode;
   mode_e              old_mode_q, old_mode_d;
   logic [10:0]        old_addr_q, old_addr_d;
   logic [BANK_W-1:0]  bank_q, bank_d;
   logic [BANK_W-1:0]  reg_q, reg_d;
   logic [TBL_W-1:0]   col_q, col_d;

   logic               tick;
   logic               stable;
   logic               mode_chg;
   logic               frame;
   logic               col_wr;
   logic               reg_wr;
   logic [5:0]         rd_col;
   logic [BANK_W-1:0]  rd_bank;
   logic               hit;
   logic [BANK_W-1:0]  hit_bank;

   assign mode     = mode_e'(MODE);
   assign tick     = PCK2B_EN;
   assign stable   = (ADDR == old_addr_q);
   assign mode_chg = tick & (mode != old_mode_q);
   assign frame    = tick & is_frame_start(ADDR, PBUS);
   assign col_wr   = tick & stable & (mode == MODE_COL) &
                     (ADDR[10:8] == COL_WR_PAGE) & (PBUS[14:12] == TAG_CMD);
   assign reg_wr   = tick & stable & (mode == MODE_DIRECT) &
                     (ADDR == DIRECT_ADDR) & (PBUS[14:12] == TAG_CMD);
   assign rd_col   = ADDR[10:5];
   assign BANK     = bank_q;

   neo_cmc_line_table #(
      .BANK_W (BANK_W),
      .LINES  (LINES)
   ) u_line_table (
      .CLK       (CLK),
      .RESET     (RESET),
      .tick      (tick),
      .stable    (stable),
      .line_mode (mode == MODE_LINE),
      .clear     (mode_chg),
      .frame     (frame),
      .addr      (ADDR),
      .pbus      (PBUS),
      .hit       (hit),
      .hit_bank  (hit_bank)
   );

   // Column readout from the registered table; columns past COLS read as 0.
   always_comb begin
      rd_bank = '0;
      for (int c = 0; c < COLS; c++) begin
         if (int'(rd_col) == c) rd_bank = col_q[c*BANK_W +: BANK_W];
      end
   end

   always_comb begin
      old_addr_d = old_addr_q;
      old_mode_d = old_mode_q;
      col_d      = col_q;
      reg_d      = reg_q;
      bank_d     = bank_q;

      if (tick) begin
         old_addr_d = ADDR;
         old_mode_d = mode;
      end

      // Group g covers bits [12g +: 12]; bits past the table end are dropped.
      if (col_wr) begin
         for (int i = 0; i < TBL_W; i++) begin
            if ((i / GROUP_BITS) == int'(ADDR[7:5])) col_d[i] = ~PBUS[i % GROUP_BITS];
         end
      end

      if (reg_wr) reg_d = ~PBUS[BANK_W-1:0];

      if (tick) begin
         if (mode == MODE_OFF || mode_chg) begin
            bank_d = '0;
         end else if (mode == MODE_COL && stable) begin
            bank_d = rd_bank;
         end else if (mode == MODE_DIRECT) begin
            // Follows the register including a write on this same tick.
            bank_d = reg_d;
         end else if (hit) begin
            bank_d = hit_bank;
         end else if (frame) begin
            bank_d = FRAME_VAL;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         old_addr_q <= '0;
         old_mode_q <= MODE_OFF;
         col_q      <= '0;
         reg_q      <= '0;
         bank_q     <= '0;
      end else begin
         old_addr_q <= old_addr_d;
         old_mode_q <= old_mode_d;
         col_q      <= col_d;
         reg_q      <= reg_d;
         bank_q     <= bank_d;
      end
   end

endmodule : neo_cmc_bank_gen

// File: tb/tb_neo_cmc_bank_gen.sv
// ---------------------------------------------------------------------------
// tb_neo_cmc_bank_gen
//   Directed bench for neo_cmc_bank_gen (BANK_W=2, LINES=32, COLS=40,
//   FRAME_BANK=1). Every tick pushes its hand-computed BANK value into a
//   scoreboard queue; a monitor pops and compares after each tick edge.
// ---------------------------------------------------------------------------
module tb_neo_cmc_bank_gen;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        PCK2B_EN;
   logic [14:0] PBUS;
   logic [10:0] ADDR;
   logic [1:0]  MODE;
   logic [1:0]  BANK;

   always #5 CLK = ~CLK;

   neo_cmc_bank_gen #(
      .BANK_W     (2),
      .LINES      (32),
      .COLS       (40),
      .FRAME_BANK (1)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .PCK2B_EN (PCK2B_EN),
      .PBUS     (PBUS),
      .ADDR     (ADDR),
      .MODE     (MODE),
      .BANK     (BANK)
   );

   typedef struct {
      int    exp;
      string name;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: BANK=%0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One tick with the given fetch; expected BANK after the tick edge.
   task automatic tk(input logic [10:0] a, input logic [14:0] p,
                     input logic [1:0] m, input int e, input string n);
      exp_t x;
      @(negedge CLK);
      RESET    = 1'b0;
      ADDR     = a;
      PBUS     = p;
      MODE     = m;
      PCK2B_EN = 1'b1;
      x.exp  = e;
      x.name = n;
      sb_q.push_back(x);
   endtask

   // Reset on a tick cycle whose fetch would otherwise load BANK.
   task automatic rst_tk(input logic [10:0] a, input logic [14:0] p,
                         input logic [1:0] m, input string n);
      exp_t x;
      @(negedge CLK);
      RESET    = 1'b1;
      ADDR     = a;
      PBUS     = p;
      MODE     = m;
      PCK2B_EN = 1'b1;
      x.exp  = 0;
      x.name = n;
      sb_q.push_back(x);
   endtask

   // Monitor: after every tick edge, pop one expectation and compare.
   initial begin
      exp_t x;
      forever begin
         @(posedge CLK);
         if (PCK2B_EN) begin
            @(negedge CLK);
            if (sb_q.size() == 0) begin
               check("unexpected_tick", int'(BANK), -1);
            end else begin
               x = sb_q.pop_front();
               check(x.name, int'(BANK), x.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RESET    = 1'b1;
      PCK2B_EN = 1'b0;
      ADDR     = '0;
      PBUS     = '0;
      MODE     = 2'd0;
      repeat (3) @(negedge CLK);

      rst_tk(11'h7E2, 15'h0000, 2'd1, "reset_state");

      // Line table: arm entry 0, bank=~2=1 with lo, then frame start and trigger.
      tk(11'h500, 15'h0200, 2'd1, 0, "mode1_enter");
      tk(11'h500, 15'h0200, 2'd1, 0, "arm_write");
      tk(11'h580, 15'h0F02, 2'd1, 0, "bank_write_a");
      tk(11'h580, 15'h0F02, 2'd1, 0, "bank_write_b");
      tk(11'h7E2, 15'h0000, 2'd1, 1, "frame_start");
      tk(11'h700, 15'h0000, 2'd1, 1, "trig_unstable");
      tk(11'h700, 15'h0000, 2'd1, 1, "trig_hit");
      tk(11'h700, 15'h0000, 2'd1, 1, "trig_skip_advance");

      // Re-bank entry 0 to 3, walk lines 1..31, wrap to 0 and hit again.
      tk(11'h580, 15'h0F00, 2'd1, 1, "rebank_a");
      tk(11'h580, 15'h0F00, 2'd1, 1, "rebank_b");
      tk(11'h700, 15'h0000, 2'd1, 1, "scan_unstable");
      for (int i = 1; i <= 31; i++) tk(11'h700, 15'h0000, 2'd1, 1, "line_scan");
      tk(11'h700, 15'h0000, 2'd1, 3, "line_wrap_hit");
      tk(11'h700, 15'h0000, 2'd1, 3, "wrap_skip");

      // Entry 1 armed with bank 2 but lo=0: no load on line 1.
      tk(11'h502, 15'h0200, 2'd1, 3, "arm1_a");
      tk(11'h502, 15'h0200, 2'd1, 3, "arm1_b");
      tk(11'h582, 15'h0E01, 2'd1, 3, "bank1_a");
      tk(11'h582, 15'h0E01, 2'd1, 3, "bank1_b");
      tk(11'h700, 15'h0000, 2'd1, 3, "lo_unstable");
      tk(11'h700, 15'h0000, 2'd1, 3, "lo_gate");

      // Mid-run reset clears BANK, line and every entry.
      rst_tk(11'h700, 15'h0000, 2'd1, "reset_mid");
      tk(11'h7E2, 15'h0000, 2'd1, 0, "modechg_beats_frame");
      tk(11'h7E2, 15'h0000, 2'd1, 1, "entries_cleared");
      tk(11'h700, 15'h0000, 2'd1, 1, "post_rst_unstable");
      tk(11'h700, 15'h0000, 2'd1, 1, "post_rst_miss");

      // Column table: group 1 <= 0x00F; probe columns around it and the edge.
      tk(11'h520, 15'h7FF0, 2'd2, 0, "mode2_enter");
      tk(11'h520, 15'h7FF0, 2'd2, 0, "grp1_write");
      tk(11'h0C0, 15'h0000, 2'd2, 0, "col6_unstable");
      tk(11'h0C0, 15'h0000, 2'd2, 3, "col6");
      tk(11'h100, 15'h0000, 2'd2, 3, "col8_unstable");
      tk(11'h100, 15'h0000, 2'd2, 0, "col8");
      tk(11'h0E0, 15'h0000, 2'd2, 0, "col7_unstable");
      tk(11'h0E0, 15'h0000, 2'd2, 3, "col7");
      tk(11'h500, 15'h0000, 2'd2, 3, "col40_unstable");
      tk(11'h500, 15'h0000, 2'd2, 0, "col40_out_of_range");
      tk(11'h5C0, 15'h7000, 2'd2, 0, "grp6_unstable");
      tk(11'h5C0, 15'h7000, 2'd2, 0, "grp6_write");
      tk(11'h460, 15'h0000, 2'd2, 0, "col35_unstable");
      tk(11'h460, 15'h0000, 2'd2, 0, "col35");
      tk(11'h480, 15'h0000, 2'd2, 0, "col36_unstable");
      tk(11'h480, 15'h0000, 2'd2, 3, "col36");
      tk(11'h4E0, 15'h0000, 2'd2, 3, "col39_unstable");
      tk(11'h4E0, 15'h0000, 2'd2, 3, "col39");

      // Direct register.
      tk(11'h7E0, 15'h7FFE, 2'd3, 0, "mode3_enter");
      tk(11'h7E0, 15'h7FFE, 2'd3, 1, "direct_write");
      tk(11'h7E1, 15'h7FFD, 2'd3, 1, "direct_toggle_a");
      tk(11'h7E0, 15'h7FFD, 2'd3, 1, "direct_toggle_b");
      tk(11'h7E1, 15'h7FFD, 2'd3, 1, "direct_toggle_c");
      tk(11'h7E0, 15'h7FFD, 2'd3, 1, "direct_toggle_d");
      tk(11'h7E0, 15'h7FFC, 2'd3, 3, "direct_rewrite");
      tk(11'h7E0, 15'h0FFF, 2'd3, 3, "direct_tag_ignored");

      // Column table survives a trip through mode 0, including a write attempt.
      tk(11'h0C0, 15'h0000, 2'd2, 0, "mode2_reenter");
      tk(11'h0C0, 15'h0000, 2'd2, 3, "col6_again");
      tk(11'h0C0, 15'h0000, 2'd0, 0, "mode0_switch");
      tk(11'h520, 15'h7000, 2'd0, 0, "mode0_unstable");
      tk(11'h520, 15'h7000, 2'd0, 0, "mode0_write_ignored");
      tk(11'h100, 15'h0000, 2'd2, 0, "mode2_back");
      tk(11'h100, 15'h0000, 2'd2, 0, "col8_intact");
      tk(11'h0C0, 15'h0000, 2'd2, 0, "col6_unstable2");
      tk(11'h0C0, 15'h0000, 2'd2, 3, "readout_resumes");

      // No ticks for 10 CLKs while inputs wander: nothing may move.
      @(negedge CLK);
      PCK2B_EN = 1'b0;
      ADDR     = 11'h100;
      PBUS     = 15'h7000;
      MODE     = 2'd0;
      repeat (9) @(negedge CLK);
      tk(11'h0C0, 15'h0000, 2'd2, 3, "idle_hold");
      tk(11'h100, 15'h0000, 2'd2, 3, "post_idle_unstable");
      tk(11'h100, 15'h0000, 2'd2, 0, "post_idle_read");

      @(negedge CLK);
      PCK2B_EN = 1'b0;
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge CLK);
      if (sb_q.size() != 0) check("scoreboard_drain", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_neo_cmc_bank_gen
